dcache_assoc_wb: RTL

//  Parametrised N-way set-associative write-back, write-allocate data cache between the LSQ and the line-wide memory port.

---
 rtl/dcache_assoc_wb.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_assoc_wb.sv
// dcache_assoc_wb: N-way set-associative write-back, write-allocate data cache.
// True-LRU replacement, byte/half/word accesses with alignment checking,
// dirty-victim writeback and blocking miss refill. One request in flight.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_*                     LSQ request (valid/ready, write, size, addr, wdata)
//   resp_*                    one-cycle response (valid, data, hit, err)
//   mem_req_*                 line-wide memory request (writeback or refill read)
//   mem_resp_*                refill line return
//
// state     | meaning
// S_IDLE    | ready for a new request
// S_LOOKUP  | tag compare, hit/error response or victim selection
// S_WB      | write dirty victim line back to memory
// S_RF_REQ  | issue refill read for the requested line
// S_RF_WAIT | wait for refill data, install line (and merge store)
// S_RESP    | respond to a miss from the refilled line
module dcache_assoc_wb #(
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 128,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_data,
  output logic                    resp_hit,
  output logic                    resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [LINE_BYTES*8-1:0] mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_resp_data
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_RF_REQ, S_RF_WAIT, S_RESP} state_e;
  state_e state_q, state_d;

  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WAY_W-1:0]  vict_q, vict_d;

  logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_d   [NUM_WAYS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF_W-1:0]  off;
  logic              req_err, hit, inv_found;
  logic [WAY_W-1:0]  hit_way, vict_sel, acc_way;
  logic [LINE_W-1:0] line_cur, line_d;
  logic              hit_upd, hit_wr, refill, arr_we;

  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] line,
      input logic [OFF_W-1:0] o, input logic [1:0] sz, input logic [31:0] wd);
    logic [LINE_W-1:0] r;
    int nb;
    r  = line;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int b = 0; b < 4; b++)
      if (b < nb && int'(o) + b < LINE_BYTES) r[(int'(o) + b) * 8 +: 8] = wd[b * 8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [LINE_W-1:0] line,
      input logic [OFF_W-1:0] o, input logic [1:0] sz);
    logic [31:0] r;
    int nb;
    r  = '0;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int b = 0; b < 4; b++)
      if (b < nb && int'(o) + b < LINE_BYTES) r[b * 8 +: 8] = line[(int'(o) + b) * 8 +: 8];
    return r;
  endfunction

  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign off = addr_q[OFF_W-1:0];

  assign req_err = (size_q == 2'd3) || (size_q == 2'd1 && addr_q[0]) ||
                   (size_q == 2'd2 && addr_q[1:0] != 2'b00);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vict_sel  = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        vict_sel  = WAY_W'(w);
      end
    if (!inv_found)
      for (int w = 0; w < NUM_WAYS; w++)
        if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1)) vict_sel = WAY_W'(w);
  end

  assign acc_way  = (state_q == S_LOOKUP) ? hit_way : vict_q;
  assign line_cur = data_q[idx][acc_way];
  assign hit_upd  = (state_q == S_LOOKUP) && !req_err && hit;
  assign hit_wr   = hit_upd && wr_q;
  assign refill   = (state_q == S_RF_WAIT) && mem_resp_valid;
  assign arr_we   = hit_wr || refill;

  always_comb begin
    line_d = refill ? mem_resp_data : line_cur;
    if (wr_q) line_d = merge_line(line_d, off, size_q, wdata_q);
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      age_d[w] = age_q[idx][w];
      if (WAY_W'(w) == acc_way)                   age_d[w] = '0;
      else if (age_q[idx][w] < age_q[idx][acc_way]) age_d[w] = age_q[idx][w] + WAY_W'(1);
    end
  end

  // FSM state register (request latch and victim travel with it)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      vict_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      vict_q  <= vict_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    vict_d  = vict_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        wr_d    = req_write;
        size_d  = req_size;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (req_err || hit) state_d = S_IDLE;
        else begin
          vict_d  = vict_sel;
          state_d = (valid_q[idx][vict_sel] && dirty_q[idx][vict_sel]) ? S_WB : S_RF_REQ;
        end
      end
      S_WB:      if (mem_req_ready)  state_d = S_RF_REQ;
      S_RF_REQ:  if (mem_req_ready)  state_d = S_RF_WAIT;
      S_RF_WAIT: if (mem_resp_valid) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_err      = 1'b0;
    resp_data     = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_LOOKUP: begin
        if (req_err) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          if (!wr_q) resp_data = extract(line_cur, off, size_q);
        end
      end
      S_WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[idx][vict_q], idx, {OFF_W{1'b0}}};
        mem_req_wdata = data_q[idx][vict_q];
      end
      S_RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, idx, {OFF_W{1'b0}}};
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (!wr_q) resp_data = extract(line_cur, off, size_q);
      end
      default: ;
    endcase
  end

  // Data and tag arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (arr_we) data_q[idx][acc_way] <= line_d;
    if (refill) tag_q[idx][vict_q]   <= tag;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (refill) begin
        valid_q[idx][vict_q] <= 1'b1;
        dirty_q[idx][vict_q] <= wr_q;
      end else if (hit_wr) begin
        dirty_q[idx][hit_way] <= 1'b1;
      end
      if (hit_upd || refill)
        for (int w = 0; w < NUM_WAYS; w++) age_q[idx][w] <= age_d[w];
    end
  end

endmodule
